// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: merges the fast (0-wait) and slow (loads, FPU) result
// streams onto the single register-file write port. It also keeps a 64-entry
// busy scoreboard (gpr 0-31, fpr 32-63) of pending slow destinations, so that
// decode stalls on RAW/WAW hazards.
module writeback_scoreboard #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [5:0]  iss_rs,
    input  logic [5:0]  iss_rt,
    input  logic [1:0]  iss_rw,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  iss_wait,
    output logic        iss_stall,
    input  logic        fast_valid,
    input  logic [1:0]  fast_rw,
    input  logic [4:0]  fast_rd,
    input  logic [31:0] fast_data,
    input  logic        slow_valid,
    output logic        slow_ready,
    input  logic [1:0]  slow_rw,
    input  logic [4:0]  slow_rd,
    input  logic [31:0] slow_data,
    output logic [1:0]  wb_rw,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Scoreboard key: fpr results live in the upper half of the busy vector.
    function automatic logic [5:0] key_of(input logic [1:0] rw, input logic [4:0] rd);
        return {(rw == 2'b10), rd};
    endfunction

    logic [63:0]      busy;
    wr_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    logic        fast_wr;
    logic        head_valid;
    logic        slow_acc;
    logic        slow_keep;
    logic [5:0]  dest_key;
    logic        accept;
    wr_t         slow_entry;
    wr_t         win_p0;
    logic        win_valid_p0;
    logic        win_slow_p0;
    logic        enq;
    logic        deq;
    logic [63:0] set_mask;
    logic [63:0] clr_mask;

    assign slow_ready = (count != FULL_CNT);
    assign slow_acc   = slow_valid & slow_ready;
    // A slow result with no destination is accepted but never stored or written.
    assign slow_keep  = slow_acc & (slow_rw != 2'b00);
    assign fast_wr    = fast_valid & (fast_rw != 2'b00);
    assign head_valid = (count != '0);
    assign slow_entry = '{rw: slow_rw, rd: slow_rd, data: slow_data};
    assign dest_key   = key_of(iss_rw, iss_rd);
    assign iss_stall  = iss_valid & (busy[iss_rs] | busy[iss_rt] |
                                     ((iss_rw != 2'b00) & busy[dest_key]));
    assign accept     = iss_valid & ~iss_stall;
    assign idle       = (busy == '0) & (count == '0);

    // Write-port arbitration: fast beats FIFO head beats incoming slow.
    always_comb begin
        win_p0       = '0;
        win_valid_p0 = 1'b0;
        win_slow_p0  = 1'b0;
        enq          = 1'b0;
        deq          = 1'b0;
        if (fast_wr) begin
            win_p0       = '{rw: fast_rw, rd: fast_rd, data: fast_data};
            win_valid_p0 = 1'b1;
            enq          = slow_keep;
        end else if (head_valid) begin
            win_p0       = fifo_mem[head_ptr];
            win_valid_p0 = 1'b1;
            win_slow_p0  = 1'b1;
            deq          = 1'b1;
            enq          = slow_keep;
        end else if (slow_keep) begin
            win_p0       = slow_entry;
            win_valid_p0 = 1'b1;
            win_slow_p0  = 1'b1;
        end
    end

    // Busy set on slow-class issue, clear when its slow result reaches the port.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept && (iss_wait != 5'd0) && (iss_rw != 2'b00) && (dest_key != 6'd0))
            set_mask = 64'(1) << dest_key;
        if (win_valid_p0 && win_slow_p0)
            clr_mask = 64'(1) << key_of(win_p0.rw, win_p0.rd);
    end

    // Control state and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rw    <= 2'b00;
            wb_rd    <= '0;
            wb_data  <= '0;
            busy     <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (win_valid_p0) begin
                // Writes to gpr 0 keep their slot but are not presented to decode.
                wb_rw   <= (key_of(win_p0.rw, win_p0.rd) == 6'd0) ? 2'b00 : win_p0.rw;
                wb_rd   <= win_p0.rd;
                wb_data <= win_p0.data;
            end else begin
                wb_rw <= 2'b00;
            end
            if (enq)
                tail_ptr <= tail_ptr + PTR_W'(1);
            if (deq)
                head_ptr <= head_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slow-result buffer storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (enq)
            fifo_mem[tail_ptr] <= slow_entry;
    end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Bench for writeback_scoreboard: directed vector table, multi-cycle corner
// sequences, and a randomized run against a queue-based reference model.
module tb_writeback_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [5:0]  iss_rs;
    logic [5:0]  iss_rt;
    logic [1:0]  iss_rw;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_wait;
    logic        iss_stall;
    logic        fast_valid;
    logic [1:0]  fast_rw;
    logic [4:0]  fast_rd;
    logic [31:0] fast_data;
    logic        slow_valid;
    logic        slow_ready;
    logic [1:0]  slow_rw;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic [1:0]  wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        idle;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_scoreboard #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rw(iss_rw),
        .iss_rd(iss_rd), .iss_wait(iss_wait), .iss_stall(iss_stall),
        .fast_valid(fast_valid), .fast_rw(fast_rw), .fast_rd(fast_rd), .fast_data(fast_data),
        .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_rw(slow_rw),
        .slow_rd(slow_rd), .slow_data(slow_data),
        .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data), .idle(idle)
    );

    typedef struct {
        logic        iv;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [1:0]  rw;
        logic [4:0]  rd;
        logic [4:0]  wt;
        logic        fv;
        logic [1:0]  frw;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic        sv;
        logic [1:0]  srw;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic        e_stall;
        logic        e_ready;
        logic [1:0]  e_wrw;
        logic [4:0]  e_wrd;
        logic [31:0] e_wd;
        logic        e_idle;
        logic        cd;
    } vec_t;

    typedef struct {
        logic [1:0]  rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rw = 0; iss_rd = 0; iss_wait = 0;
        fast_valid = 0; fast_rw = 0; fast_rd = 0; fast_data = 0;
        slow_valid = 0; slow_rw = 0; slow_rd = 0; slow_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic add_vec(
        input logic iv, input logic [5:0] rs, input logic [5:0] rt, input logic [1:0] rw,
        input logic [4:0] rd, input logic [4:0] wt,
        input logic fv, input logic [1:0] frw, input logic [4:0] frd, input logic [31:0] fd,
        input logic sv, input logic [1:0] srw, input logic [4:0] srd, input logic [31:0] sd,
        input logic e_stall, input logic e_ready, input logic [1:0] e_wrw,
        input logic [4:0] e_wrd, input logic [31:0] e_wd, input logic e_idle, input logic cd);
        vec_t v;
        v.iv = iv; v.rs = rs; v.rt = rt; v.rw = rw; v.rd = rd; v.wt = wt;
        v.fv = fv; v.frw = frw; v.frd = frd; v.fd = fd;
        v.sv = sv; v.srw = srw; v.srd = srd; v.sd = sd;
        v.e_stall = e_stall; v.e_ready = e_ready; v.e_wrw = e_wrw; v.e_wrd = e_wrd;
        v.e_wd = e_wd; v.e_idle = e_idle; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        //        iv rs     rt     rw  rd wt  fv frw frd fd       sv srw srd sd       stl rdy wrw wrd wd       idl cd
        add_vec(0, 0,     0,     0,  0, 0,  1, 1,  5,  32'h1234, 0, 0,  0,  0,       0,  1,  1,  5,  32'h1234, 1, 1);
        add_vec(0, 0,     0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  5,  32'h1234, 1, 1);
        add_vec(1, 0,     0,     1,  8, 1,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  5,  32'h1234, 0, 1);
        add_vec(1, 8,     0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       1,  1,  0,  5,  32'h1234, 0, 1);
        add_vec(1, 8,     0,     0,  0, 0,  0, 0,  0,  0,        1, 1,  8,  32'hAAAA, 1, 1,  1,  8,  32'hAAAA, 1, 1);
        add_vec(1, 8,     0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  8,  32'hAAAA, 1, 1);
        add_vec(1, 0,     0,     2,  2, 5,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  8,  32'hAAAA, 0, 1);
        add_vec(1, 6'h22, 0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       1,  1,  0,  8,  32'hAAAA, 0, 1);
        add_vec(1, 6'h02, 0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  8,  32'hAAAA, 0, 1);
        add_vec(1, 0,     0,     2,  2, 0,  0, 0,  0,  0,        0, 0,  0,  0,       1,  1,  0,  8,  32'hAAAA, 0, 1);
        add_vec(1, 0,     6'h22, 0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       1,  1,  0,  8,  32'hAAAA, 0, 1);
        add_vec(0, 0,     0,     0,  0, 0,  1, 1,  0,  32'h55,   0, 0,  0,  0,       0,  1,  0,  0,  0,        0, 0);
        add_vec(0, 0,     0,     0,  0, 0,  0, 0,  0,  0,        1, 2,  2,  32'hBEEF, 0, 1,  2,  2,  32'hBEEF, 1, 1);
        add_vec(1, 6'h22, 0,     0,  0, 0,  0, 0,  0,  0,        0, 0,  0,  0,       0,  1,  0,  2,  32'hBEEF, 1, 1);
        add_vec(0, 0,     0,     0,  0, 0,  0, 0,  0,  0,        1, 0,  7,  32'h77,  0,  1,  0,  2,  32'hBEEF, 1, 1);
        add_vec(0, 0,     0,     0,  0, 0,  1, 0,  9,  32'h99,   0, 0,  0,  0,       0,  1,  0,  2,  32'hBEEF, 1, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            iss_valid = vecs[i].iv; iss_rs = vecs[i].rs; iss_rt = vecs[i].rt;
            iss_rw = vecs[i].rw; iss_rd = vecs[i].rd; iss_wait = vecs[i].wt;
            fast_valid = vecs[i].fv; fast_rw = vecs[i].frw; fast_rd = vecs[i].frd;
            fast_data = vecs[i].fd;
            slow_valid = vecs[i].sv; slow_rw = vecs[i].srw; slow_rd = vecs[i].srd;
            slow_data = vecs[i].sd;
            #1;
            chk($sformatf("vec%0d iss_stall", i), 32'(iss_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d slow_ready", i), 32'(slow_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d wb_rw", i), 32'(wb_rw), 32'(vecs[i].e_wrw));
            chk($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].e_idle));
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_wrd));
                chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_wd);
            end
        end
        clr_in();
    endtask

    task automatic run_same_cycle();
        clr_in();
        iss_valid = 1; iss_rw = 1; iss_rd = 4; iss_wait = 2;
        tick();
        clr_in();
        fast_valid = 1; fast_rw = 1; fast_rd = 3; fast_data = 32'h33;
        slow_valid = 1; slow_rw = 1; slow_rd = 4; slow_data = 32'h44;
        #1;
        chk("same slow_ready", 32'(slow_ready), 1);
        @(posedge clk); #1;
        clr_in();
        chk("same wb_rd first", 32'(wb_rd), 3);
        chk("same wb_data first", wb_data, 32'h33);
        chk("same idle first", 32'(idle), 0);
        tick();
        chk("same wb_rw second", 32'(wb_rw), 1);
        chk("same wb_rd second", 32'(wb_rd), 4);
        chk("same wb_data second", wb_data, 32'h44);
        chk("same idle second", 32'(idle), 1);
        tick();
        chk("same wb_rw quiet", 32'(wb_rw), 0);
    endtask

    task automatic run_fifo_fill();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rw = 1; iss_rd = 5'(10 + i); iss_wait = 3;
            tick();
        end
        clr_in();
        for (int i = 0; i < 6; i++) begin
            fast_valid = 1; fast_rw = 1; fast_rd = 5'(20 + i); fast_data = 32'(32'h100 + i);
            slow_valid = 1; slow_rw = 1;
            slow_rd    = (i < 4) ? 5'(10 + i) : 5'd14;
            slow_data  = (i < 4) ? 32'(32'hA0 + i) : 32'hA4;
            #1;
            chk($sformatf("fill%0d slow_ready", i), 32'(slow_ready), (i < 4) ? 1 : 0);
            @(posedge clk); #1;
            chk($sformatf("fill%0d wb_rd", i), 32'(wb_rd), 32'(20 + i));
        end
        fast_valid = 0; fast_rw = 0;
        for (int r = 0; r < 5; r++) begin
            if (r >= 2) begin
                slow_valid = 0; slow_rw = 0;
            end
            #1;
            if (r < 2)
                chk($sformatf("drain%0d slow_ready", r), 32'(slow_ready), (r == 0) ? 0 : 1);
            @(posedge clk); #1;
            chk($sformatf("drain%0d wb_rw", r), 32'(wb_rw), 1);
            chk($sformatf("drain%0d wb_rd", r), 32'(wb_rd), 32'(10 + r));
            chk($sformatf("drain%0d wb_data", r), wb_data, 32'(32'hA0 + r));
        end
        chk("drain idle", 32'(idle), 1);
        clr_in();
    endtask

    task automatic run_mid_reset();
        clr_in();
        iss_valid = 1; iss_rw = 1; iss_rd = 15; iss_wait = 2;
        tick();
        clr_in();
        fast_valid = 1; fast_rw = 1; fast_rd = 21; fast_data = 32'h21;
        slow_valid = 1; slow_rw = 1; slow_rd = 15; slow_data = 32'hF;
        tick();
        clr_in();
        chk("mrst idle before", 32'(idle), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst wb_rw", 32'(wb_rw), 0);
        chk("mrst idle", 32'(idle), 1);
        chk("mrst slow_ready", 32'(slow_ready), 1);
        tick();
        chk("mrst no leak", 32'(wb_rw), 0);
    endtask

    task automatic run_random(input int cycles);
        bit [63:0]  mb;
        wr_t        mq[$];
        logic [5:0] pend[$];
        wr_t        cur;
        bit         have_cur;
        logic [1:0] m_wrw;
        logic [4:0] m_wrd;
        logic [31:0] m_wd;
        do_reset();
        mb = '0; have_cur = 0; cur = '{rw: 0, rd: 0, data: 0};
        m_wrw = 0; m_wrd = 0; m_wd = 0;
        for (int c = 0; c < cycles; c++) begin
            int         fprob;
            logic [5:0] dkey;
            logic       e_stall, e_ready, acc, consumed, win_ok, win_slow;
            wr_t        win;
            fprob = (((c / 150) % 2) == 1) ? 85 : 30;
            iss_valid = ($urandom_range(0, 99) < 50);
            iss_rs    = 6'($urandom_range(0, 63));
            iss_rt    = 6'($urandom_range(0, 63));
            if (pend.size() > 0 && $urandom_range(0, 1) == 1)
                iss_rs = pend[$urandom_range(0, pend.size() - 1)];
            iss_rw   = 2'($urandom_range(0, 2));
            iss_rd   = 5'($urandom_range(0, 31));
            if (pend.size() > 0 && $urandom_range(0, 3) == 0) begin
                logic [5:0] k;
                k = pend[$urandom_range(0, pend.size() - 1)];
                iss_rw = k[5] ? 2'b10 : 2'b01;
                iss_rd = k[4:0];
            end
            iss_wait   = 5'($urandom_range(0, 3));
            fast_valid = ($urandom_range(0, 99) < fprob);
            fast_rw    = 2'($urandom_range(0, 2));
            fast_rd    = 5'($urandom_range(0, 31));
            fast_data  = $urandom;
            if (!have_cur) begin
                if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                    int idx;
                    idx = $urandom_range(0, pend.size() - 1);
                    cur.rw = pend[idx][5] ? 2'b10 : 2'b01;
                    cur.rd = pend[idx][4:0];
                    cur.data = $urandom;
                    pend.delete(idx);
                    have_cur = 1;
                end else if ($urandom_range(0, 19) == 0) begin
                    cur.rw = 0; cur.rd = 5'($urandom_range(0, 31)); cur.data = $urandom;
                    have_cur = 1;
                end
            end
            slow_valid = have_cur;
            slow_rw = cur.rw; slow_rd = cur.rd; slow_data = cur.data;
            #1;
            dkey    = {(iss_rw == 2'b10), iss_rd};
            e_stall = iss_valid & (mb[iss_rs] | mb[iss_rt] | ((iss_rw != 0) & mb[dkey]));
            e_ready = (mq.size() < 4);
            chk("rnd iss_stall", 32'(iss_stall), 32'(e_stall));
            chk("rnd slow_ready", 32'(slow_ready), 32'(e_ready));
            chk("rnd idle", 32'(idle), 32'((mb == 0) && (mq.size() == 0)));
            acc = have_cur & e_ready;
            consumed = 0; win_ok = 0; win_slow = 0; win = '{rw: 0, rd: 0, data: 0};
            if (fast_valid && fast_rw != 0) begin
                win = '{rw: fast_rw, rd: fast_rd, data: fast_data}; win_ok = 1;
            end else if (mq.size() > 0) begin
                win = mq.pop_front(); win_ok = 1; win_slow = 1;
            end else if (acc && cur.rw != 0) begin
                win = cur; win_ok = 1; win_slow = 1; consumed = 1;
            end
            if (acc && cur.rw != 0 && !consumed)
                mq.push_back(cur);
            if (acc)
                have_cur = 0;
            if (win_ok) begin
                m_wrw = (win.rw == 2'b01 && win.rd == 0) ? 2'b00 : win.rw;
                m_wrd = win.rd;
                m_wd  = win.data;
                if (win_slow)
                    mb[{(win.rw == 2'b10), win.rd}] = 1'b0;
            end else begin
                m_wrw = 0;
            end
            if (iss_valid && !e_stall && iss_wait != 0 && iss_rw != 0 && dkey != 0) begin
                mb[dkey] = 1'b1;
                pend.push_back(dkey);
            end
            @(posedge clk); #1;
            chk("rnd wb_rw", 32'(wb_rw), 32'(m_wrw));
            chk("rnd wb_rd", 32'(wb_rd), 32'(m_wrd));
            chk("rnd wb_data", wb_data, m_wd);
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset wb_rw", 32'(wb_rw), 0);
        chk("reset wb_rd", 32'(wb_rd), 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset idle", 32'(idle), 1);
        chk("reset slow_ready", 32'(slow_ready), 1);
        chk("reset iss_stall", 32'(iss_stall), 0);
        run_table();
        run_same_cycle();
        run_fifo_fill();
        run_mid_reset();
        run_random(3000);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
